// File: rtl/snk68_bus_pkg.sv
// snk68_bus_pkg: shared FSM state type, board selectors and per-PCB region
// tables used by m68k_bus_decoder and m68k_region_match.
// A board-level wrapper picks its map with, for example,
// REGION_BASE(pcb_region_base(A7008)).
package snk68_bus_pkg;

  // Bus-cycle tracker states
  typedef enum logic [2:0] {
    RECOVER = 3'd0,
    IDLE    = 3'd1,
    WAIT    = 3'd2,
    ACK     = 3'd3,
    BERR    = 3'd4
  } bus_state_t;

  // Board variants
  localparam int A7007_A8007 = 0;
  localparam int A7008       = 1;
  localparam int A7008_SS    = 2;

  // Geometry of the board tables (matches the decoder defaults)
  localparam int PCB_N_REGIONS = 16;
  localparam int PCB_ADDR_W    = 24;
  localparam int PCB_WAIT_W    = 4;

  typedef struct packed {
    logic [PCB_ADDR_W-1:0] base;
    logic [PCB_ADDR_W-1:0] mask;
    logic [PCB_WAIT_W-1:0] waits;
    logic                  ext;
    logic [1:0]            dir;
  } region_t;

  // Low bit of field idx inside a packed table of width-bit fields
  function automatic int unsigned field_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

  // One region entry of a board map; unused entries have dir=00 so they never hit
  function automatic region_t pcb_region(input int pcb, input int idx);
    region_t r;
    r = '{base: 24'h000000, mask: 24'h000000, waits: 4'd0, ext: 1'b0, dir: 2'b00};
    case (idx)
      0: r = '{24'h000000, (pcb == A7008_SS) ? 24'hF80000 : 24'hFC0000, 4'd0, 1'b0, 2'b01}; // program ROM
      1: r = '{24'h040000, 24'hFFC000, 4'd0, 1'b0, 2'b11};                                  // work RAM
      2: r = '{24'h080000, 24'hFFFF00, 4'd1, 1'b0, 2'b01};                                  // player inputs
      3: r = '{24'h080000, 24'hFFFF00, 4'd1, 1'b0, 2'b10};                                  // sound latch
      4: r = '{(pcb == A7007_A8007) ? 24'h100000 : 24'h200000, 24'hFF8000, 4'd1, 1'b0, 2'b11}; // sprite RAM
      5: r = '{24'h400000, 24'hFFF000, 4'd1, 1'b0, 2'b11};                                  // palette
      6: r = '{24'h0E0000, 24'hFFFF00, 4'd2, 1'b0, 2'b01};                                  // DIP switches
      default: r = '{24'h000000, 24'h000000, 4'd0, 1'b0, 2'b00};
    endcase
    return r;
  endfunction

  function automatic logic [PCB_N_REGIONS*PCB_ADDR_W-1:0] pcb_region_base(input int pcb);
    logic [PCB_N_REGIONS*PCB_ADDR_W-1:0] t;
    t = '0;
    for (int i = 0; i < PCB_N_REGIONS; i++) t[field_lo(i, PCB_ADDR_W) +: PCB_ADDR_W] = pcb_region(pcb, i).base;
    return t;
  endfunction

  function automatic logic [PCB_N_REGIONS*PCB_ADDR_W-1:0] pcb_region_mask(input int pcb);
    logic [PCB_N_REGIONS*PCB_ADDR_W-1:0] t;
    t = '0;
    for (int i = 0; i < PCB_N_REGIONS; i++) t[field_lo(i, PCB_ADDR_W) +: PCB_ADDR_W] = pcb_region(pcb, i).mask;
    return t;
  endfunction

  function automatic logic [PCB_N_REGIONS*PCB_WAIT_W-1:0] pcb_region_wait(input int pcb);
    logic [PCB_N_REGIONS*PCB_WAIT_W-1:0] t;
    t = '0;
    for (int i = 0; i < PCB_N_REGIONS; i++) t[field_lo(i, PCB_WAIT_W) +: PCB_WAIT_W] = pcb_region(pcb, i).waits;
    return t;
  endfunction

  function automatic logic [PCB_N_REGIONS-1:0] pcb_region_ext(input int pcb);
    logic [PCB_N_REGIONS-1:0] t;
    t = '0;
    for (int i = 0; i < PCB_N_REGIONS; i++) t[i] = pcb_region(pcb, i).ext;
    return t;
  endfunction

  function automatic logic [PCB_N_REGIONS*2-1:0] pcb_region_dir(input int pcb);
    logic [PCB_N_REGIONS*2-1:0] t;
    t = '0;
    for (int i = 0; i < PCB_N_REGIONS; i++) t[field_lo(i, 2) +: 2] = pcb_region(pcb, i).dir;
    return t;
  endfunction

endpackage

// File: rtl/m68k_region_match.sv
// m68k_region_match: combinational address/direction compare against the
// region table; lowest matching index wins so the result is one region or none.
module m68k_region_match
  import snk68_bus_pkg::*;
#(
  parameter int                          N_REGIONS   = 16,
  parameter int                          ADDR_W      = 24,
  parameter int                          IDX_W       = 4,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = '0,
  parameter logic [N_REGIONS*2-1:0]      REGION_DIR  = '1
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rw,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx
);

  logic [N_REGIONS-1:0] w_hit_vec;

  for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_mask;
    logic              w_dir_ok;
    assign w_base       = REGION_BASE[field_lo(g, ADDR_W) +: ADDR_W];
    assign w_mask       = REGION_MASK[field_lo(g, ADDR_W) +: ADDR_W];
    // dir bit0 enables reads (rw=1), bit1 enables writes (rw=0)
    assign w_dir_ok     = i_rw ? REGION_DIR[field_lo(g, 2)] : REGION_DIR[field_lo(g, 2) + 1];
    assign w_hit_vec[g] = (((i_addr ^ w_base) & w_mask) == '0) && w_dir_ok;
  end

  // Priority select: scan from the top so the lowest hitting index is written last
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      o_idx = w_hit_vec[i] ? IDX_W'(i) : o_idx;
      o_hit = o_hit | w_hit_vec[i];
    end
  end

endmodule

// File: rtl/m68k_bus_decoder.sv
// m68k_bus_decoder: registered 68000 chip-select decoder with per-region
// wait states, external-ready handshake and DTACK generation.
// Optional feature macro: M68K_BUS_BERR_EN adds m68k_berr_n and a bus-error
// timeout in WAIT and for unmapped cycles.
module m68k_bus_decoder
  import snk68_bus_pkg::*;
#(
  parameter int                          N_REGIONS   = 16,
  parameter int                          ADDR_W      = 24,
  parameter int                          WAIT_W      = 4,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = '0,
  parameter logic [N_REGIONS*WAIT_W-1:0] REGION_WAIT = '0,
  parameter logic [N_REGIONS-1:0]        REGION_EXT  = '0,
  parameter logic [N_REGIONS*2-1:0]      REGION_DIR  = '1,
  parameter int                          BERR_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    m68k_a,
  input  logic                 m68k_as_n,
  input  logic                 m68k_rw,
  input  logic [N_REGIONS-1:0] ext_ready,
  output logic [N_REGIONS-1:0] cs,
  output logic                 cs_rd,
  output logic                 cs_wr,
  output logic                 m68k_dtack_n,
  output logic                 unmapped
`ifdef M68K_BUS_BERR_EN
  ,
  output logic                 m68k_berr_n
`endif
);

  localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  bus_state_t           r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [WAIT_W-1:0]    r_cnt;
  logic [N_REGIONS-1:0] r_cs;
  logic                 r_cs_rd;
  logic                 r_cs_wr;
  logic                 r_dtack_n;
  logic                 r_unmapped;

  logic                 w_hit;
  logic [IDX_W-1:0]     w_idx;
  logic [WAIT_W-1:0]    w_wait_sel;
  logic                 w_ext_sel;
  logic                 w_ready_sel;

  m68k_region_match #(
    .N_REGIONS   (N_REGIONS),
    .ADDR_W      (ADDR_W),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .REGION_DIR  (REGION_DIR)
  ) u_match (
    .i_addr (m68k_a),
    .i_rw   (m68k_rw),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  // Wait count of the region being decoded now; EXT flag/ready of the latched region
  assign w_wait_sel  = REGION_WAIT[field_lo(int'(w_idx), WAIT_W) +: WAIT_W];
  assign w_ext_sel   = REGION_EXT[r_idx];
  assign w_ready_sel = ext_ready[r_idx];

`ifdef M68K_BUS_BERR_EN
  localparam int TMO_W = $clog2(BERR_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_berr_n;
  assign m68k_berr_n = r_berr_n;
`else
  logic w_unused_berr_cfg;
  assign w_unused_berr_cfg = (BERR_CYCLES != 0);
`endif

  // Bus-cycle FSM: decode on AS, count waits, handshake, acknowledge, release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RECOVER;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_cs       <= '0;
      r_cs_rd    <= 1'b0;
      r_cs_wr    <= 1'b0;
      r_dtack_n  <= 1'b1;
      r_unmapped <= 1'b0;
`ifdef M68K_BUS_BERR_EN
      r_tmo      <= '0;
      r_berr_n   <= 1'b1;
`endif
    end else begin
      r_unmapped <= 1'b0;
      case (r_state)
        // A cycle already running at reset release is skipped until AS goes high
        RECOVER: begin
          if (m68k_as_n) r_state <= IDLE;
          else           r_state <= RECOVER;
        end
        IDLE: begin
          if (!m68k_as_n) begin
`ifdef M68K_BUS_BERR_EN
            r_tmo <= '0;
`endif
            if (w_hit) begin
              r_idx   <= w_idx;
              r_cs    <= N_REGIONS'(1'b1) << w_idx;
              r_cs_rd <= m68k_rw;
              r_cs_wr <= !m68k_rw;
              r_cnt   <= w_wait_sel;
              r_state <= WAIT;
            end else begin
              r_unmapped <= 1'b1;
`ifdef M68K_BUS_BERR_EN
              r_state    <= BERR;
`else
              // open-bus: acknowledge anyway so the CPU does not hang
              r_dtack_n  <= 1'b0;
              r_state    <= ACK;
`endif
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (m68k_as_n) begin
            // CPU abandoned the cycle: drop everything, never acknowledge
            r_cs    <= '0;
            r_cs_rd <= 1'b0;
            r_cs_wr <= 1'b0;
            r_state <= IDLE;
          end
`ifdef M68K_BUS_BERR_EN
          else if (r_tmo == TMO_W'(BERR_CYCLES - 1)) begin
            r_berr_n <= 1'b0;
            r_state  <= BERR;
          end
`endif
          else begin
`ifdef M68K_BUS_BERR_EN
            r_tmo <= r_tmo + TMO_W'(1'b1);
`endif
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - WAIT_W'(1'b1);
            end else if (!w_ext_sel || w_ready_sel) begin
              r_dtack_n <= 1'b0;
              r_state   <= ACK;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        ACK: begin
          if (m68k_as_n) begin
            r_cs      <= '0;
            r_cs_rd   <= 1'b0;
            r_cs_wr   <= 1'b0;
            r_dtack_n <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_state <= ACK;
          end
        end
        BERR: begin
          if (m68k_as_n) begin
            r_cs      <= '0;
            r_cs_rd   <= 1'b0;
            r_cs_wr   <= 1'b0;
            r_dtack_n <= 1'b1;
`ifdef M68K_BUS_BERR_EN
            r_berr_n  <= 1'b1;
`endif
            r_state   <= IDLE;
          end else begin
`ifdef M68K_BUS_BERR_EN
            // unmapped cycles time out here; timed-out WAIT cycles arrive already flagged
            if (r_berr_n && (r_tmo == TMO_W'(BERR_CYCLES - 1))) r_berr_n <= 1'b0;
            else if (r_berr_n)                                   r_tmo    <= r_tmo + TMO_W'(1'b1);
            else                                                 r_berr_n <= 1'b0;
`endif
            r_state <= BERR;
          end
        end
        default: begin
          r_cs      <= '0;
          r_cs_rd   <= 1'b0;
          r_cs_wr   <= 1'b0;
          r_dtack_n <= 1'b1;
          r_state   <= RECOVER;
        end
      endcase
    end
  end

  assign cs           = r_cs;
  assign cs_rd        = r_cs_rd;
  assign cs_wr        = r_cs_wr;
  assign m68k_dtack_n = r_dtack_n;
  assign unmapped     = r_unmapped;

endmodule

// File: tb/tb_m68k_bus_decoder.sv
// tb_m68k_bus_decoder: scoreboard bench for m68k_bus_decoder (default build).
module tb_m68k_bus_decoder;

  localparam int NR = 16;
  localparam int AW = 24;
  localparam int WW = 4;

  // Board map under test
  function automatic logic [NR*AW-1:0] tb_base();
    logic [NR*AW-1:0] t;
    t = '0;
    t[0*AW +: AW] = 24'h000000;
    t[1*AW +: AW] = 24'h100000;
    t[2*AW +: AW] = 24'h080000;
    t[3*AW +: AW] = 24'h400000;
    t[5*AW +: AW] = 24'h080000;
    return t;
  endfunction

  function automatic logic [NR*AW-1:0] tb_mask();
    logic [NR*AW-1:0] t;
    t = '0;
    t[0*AW +: AW] = 24'hFC0000;
    t[1*AW +: AW] = 24'hFF0000;
    t[2*AW +: AW] = 24'hFFF000;
    t[3*AW +: AW] = 24'hFF0000;
    t[5*AW +: AW] = 24'hFFF000;
    return t;
  endfunction

  function automatic logic [NR*WW-1:0] tb_wait();
    logic [NR*WW-1:0] t;
    t = '0;
    t[1*WW +: WW] = 4'd2;
    t[3*WW +: WW] = 4'd5;
    t[5*WW +: WW] = 4'd1;
    return t;
  endfunction

  function automatic logic [NR*2-1:0] tb_dir();
    logic [NR*2-1:0] t;
    t = '0;
    t[0*2 +: 2] = 2'b11;
    t[1*2 +: 2] = 2'b11;
    t[2*2 +: 2] = 2'b01;
    t[3*2 +: 2] = 2'b11;
    t[5*2 +: 2] = 2'b10;
    return t;
  endfunction

  localparam logic [NR*AW-1:0] P_BASE = tb_base();
  localparam logic [NR*AW-1:0] P_MASK = tb_mask();
  localparam logic [NR*WW-1:0] P_WAIT = tb_wait();
  localparam logic [NR-1:0]    P_EXT  = 16'h0002;
  localparam logic [NR*2-1:0]  P_DIR  = tb_dir();

  logic          clk;
  logic          reset;
  logic [AW-1:0] m68k_a;
  logic          m68k_as_n;
  logic          m68k_rw;
  logic [NR-1:0] ext_ready;
  logic [NR-1:0] cs;
  logic          cs_rd;
  logic          cs_wr;
  logic          m68k_dtack_n;
  logic          unmapped;
`ifdef M68K_BUS_BERR_EN
  logic          m68k_berr_n;
`endif

  m68k_bus_decoder #(
    .N_REGIONS   (NR),
    .ADDR_W      (AW),
    .WAIT_W      (WW),
    .REGION_BASE (P_BASE),
    .REGION_MASK (P_MASK),
    .REGION_WAIT (P_WAIT),
    .REGION_EXT  (P_EXT),
    .REGION_DIR  (P_DIR),
    .BERR_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m68k_a       (m68k_a),
    .m68k_as_n    (m68k_as_n),
    .m68k_rw      (m68k_rw),
    .ext_ready    (ext_ready),
    .cs           (cs),
    .cs_rd        (cs_rd),
    .cs_wr        (cs_wr),
    .m68k_dtack_n (m68k_dtack_n),
    .unmapped     (unmapped)
`ifdef M68K_BUS_BERR_EN
    ,
    .m68k_berr_n  (m68k_berr_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [NR-1:0] cs;
    logic          rd;
    logic          wr;
    logic          unm;
    int            lat;
  } exp_t;

  exp_t sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decode: lowest index whose masked address and direction match
  task automatic tb_match(input logic [AW-1:0] a, input logic rw, output logic hit, output logic [3:0] idx);
    hit = 1'b0;
    idx = 4'd0;
    for (int i = 0; i < NR; i++) begin
      if (!hit && (((a ^ P_BASE[i*AW +: AW]) & P_MASK[i*AW +: AW]) == 24'h000000) &&
          (rw ? P_DIR[2*i] : P_DIR[2*i+1])) begin
        hit = 1'b1;
        idx = 4'(i);
      end
    end
  endtask

  // One CPU bus cycle; called and returns #1 after a rising edge.
  // ext_at: first cycle index at which ext_ready is seen high (-1 = never);
  // ext_pulse: one early pulse while the counter is still running;
  // abort_at: release AS at that cycle index (0 = run to DTACK).
  task automatic bus_cycle(input string tag, input logic [AW-1:0] a, input logic rw,
                           input int ext_at, input bit ext_pulse, input int abort_at);
    exp_t        e;
    exp_t        o;
    logic        hit;
    logic [3:0]  idx;
    int          n;
    tb_match(a, rw, hit, idx);
    e.cs  = hit ? (16'h0001 << idx) : 16'h0000;
    e.rd  = hit & rw;
    e.wr  = hit & ~rw;
    e.unm = ~hit;
    if (abort_at > 0)  e.lat = 0;
    else if (!hit)     e.lat = 1;
    else begin
      e.lat = int'(P_WAIT[idx*WW +: WW]) + 2;
      if (P_EXT[idx] && (ext_at + 1 > e.lat)) e.lat = ext_at + 1;
    end
    sb_q.push_back(e);

    m68k_a    = a;
    m68k_rw   = rw;
    m68k_as_n = 1'b0;
    ext_ready = '0;
    o.cs = '0; o.rd = 1'b0; o.wr = 1'b0; o.unm = 1'b0; o.lat = 0;
    n = 0;
    while (n < 40 && o.lat == 0 && !(abort_at > 0 && n >= abort_at + 3)) begin
      @(posedge clk);
      n++;
      #1;
      ext_ready = ((ext_at >= 0 && n >= ext_at) || (ext_pulse && n == 1)) ? 16'hFFFF : 16'h0000;
      if (n == 1) begin
        m68k_a  = ~a;
        m68k_rw = ~rw;
      end
      if (abort_at > 0 && n == abort_at) m68k_as_n = 1'b1;
      @(negedge clk);
      if (n == 1) begin
        o.cs  = cs;
        o.rd  = cs_rd;
        o.wr  = cs_wr;
        o.unm = unmapped;
      end
      if (!m68k_dtack_n) o.lat = n;
    end

    e = sb_q.pop_front();
    check_eq({tag, "/cs"},       32'(o.cs),  32'(e.cs));
    check_eq({tag, "/cs_rd"},    32'(o.rd),  32'(e.rd));
    check_eq({tag, "/cs_wr"},    32'(o.wr),  32'(e.wr));
    check_eq({tag, "/unmapped"}, 32'(o.unm), 32'(e.unm));
    check_eq({tag, "/dtack_lat"}, o.lat,     e.lat);
    if (abort_at == 0) begin
      check_eq({tag, "/cs_hold"}, 32'(cs), 32'(e.cs));
      m68k_as_n = 1'b1;
    end
    @(posedge clk);
    #1;
    ext_ready = '0;
    check_eq({tag, "/rel_cs"},    32'(cs),           32'h0);
    check_eq({tag, "/rel_rdwr"},  32'({cs_rd, cs_wr}), 32'h0);
    check_eq({tag, "/rel_dtack"}, 32'(m68k_dtack_n), 32'h1);
    check_eq({tag, "/rel_unm"},   32'(unmapped),     32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    m68k_as_n = 1'b1;
    m68k_a    = '0;
    m68k_rw   = 1'b1;
    ext_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset/cs",    32'(cs),           32'h0);
    check_eq("reset/rdwr",  32'({cs_rd, cs_wr}), 32'h0);
    check_eq("reset/dtack", 32'(m68k_dtack_n), 32'h1);
    check_eq("reset/unm",   32'(unmapped),     32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    bus_cycle("zw_read",   24'h001234, 1'b1, -1, 1'b0, 0);
    bus_cycle("zw_write",  24'h001234, 1'b0, -1, 1'b0, 0);
    bus_cycle("wait5",     24'h400010, 1'b1, -1, 1'b0, 0);
    bus_cycle("ext_late",  24'h100020, 1'b1, 10, 1'b1, 0);
    bus_cycle("ext_ready", 24'h100020, 1'b0,  0, 1'b0, 0);
    bus_cycle("prio_wr",   24'h080000, 1'b0, -1, 1'b0, 0);
    bus_cycle("prio_rd",   24'h080000, 1'b1, -1, 1'b0, 0);
    bus_cycle("unmapped",  24'hFFFFF0, 1'b1, -1, 1'b0, 0);
    bus_cycle("abort",     24'h400010, 1'b1, -1, 1'b0, 3);
    bus_cycle("after_abt", 24'h03FFFE, 1'b1, -1, 1'b0, 0);

    // Reset in the middle of a wait-stated cycle with AS held low
    m68k_a    = 24'h400010;
    m68k_rw   = 1'b1;
    m68k_as_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("rst_mid/cs",    32'(cs),           32'h0);
    check_eq("rst_mid/rdwr",  32'({cs_rd, cs_wr}), 32'h0);
    check_eq("rst_mid/dtack", 32'(m68k_dtack_n), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_hold/cs",    32'(cs),           32'h0);
      check_eq("rst_hold/dtack", 32'(m68k_dtack_n), 32'h1);
    end
    @(posedge clk);
    #1;
    m68k_as_n = 1'b1;
    @(posedge clk);
    #1;
    bus_cycle("after_rst", 24'h400010, 1'b1, -1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
